// File: rtl/ecg_pkg.sv
// Shared definitions for the ECG filter datapath: sample type, filter length
// and the playback state encoding.
package ecg_pkg;

  localparam int SAMPLE_W = 16;
  localparam int NTAPS    = 101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } stream_state_e;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/ecg_sample_ram.sv
// Sample buffer: one write port, one synchronous read port (data one cycle
// after the read enable). Contents are never reset.
module ecg_sample_ram
  import ecg_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic                       Clk,
  input  logic                       We,
  input  logic [ADDR_W-1:0]          Waddr,
  input  logic signed [SAMPLE_W-1:0] Wdata,
  input  logic                       Re,
  input  logic [ADDR_W-1:0]          Raddr,
  output logic signed [SAMPLE_W-1:0] Rdata
);

  sample_t mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (We) begin
      mem[Waddr] <= Wdata;
    end
    if (Re) begin
      Rdata <= mem[Raddr];
    end
  end

endmodule

// File: rtl/ecg_sample_streamer.sv
// Plays a buffered ECG record into the FIR as Xout/Xvalid strobes, one-shot or
// looped. Define STREAMER_ZERO_FLUSH_EN to append NTAPS-1 zero samples after a one-shot run.
module ecg_sample_streamer
  import ecg_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = 10,
  parameter int TICK_DIV = 4
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       Wr_en,
  input  logic [ADDR_W-1:0]          Wr_addr,
  input  logic signed [SAMPLE_W-1:0] Wr_data,
  input  logic [ADDR_W:0]            Len,
  input  logic                       Loop,
  input  logic                       Start,
  input  logic                       Stop,
  output logic signed [SAMPLE_W-1:0] Xout,
  output logic                       Xvalid,
  output logic                       Busy,
  output logic                       Done,
  output logic [1:0]                 State_dbg
);

  // Xvalid is a one-cycle strobe with no ready: the filter must take every
  // sample on the cycle it appears; Xout holds its value between strobes.

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_FLUSH = ST_FLUSH;
  localparam logic [1:0] S_DONE  = ST_DONE;

  localparam int             TW    = $clog2(TICK_DIV);
  localparam logic [TW-1:0]  T_MAX = TW'(TICK_DIV - 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [1:0]        state;
  logic [TW-1:0]     tick;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   len_q;
  logic              loop_q;
  logic              rd_stop;
  logic              rd_valid;
  logic              done_pend;
  sample_t           ram_q;
  sample_t           xout_q;
  logic              xvalid_q;

  logic              start_ok;
  logic              rd_fire;
  logic              is_last;
  logic [ADDR_W:0]   len_clamped;

  assign start_ok    = Start && !Stop && ((state == S_IDLE) || (state == S_DONE));
  assign len_clamped = (Len > DEPTH_L) ? DEPTH_L : Len;
  assign rd_fire     = (state == S_RUN) && (tick == '0) && !rd_stop;
  assign is_last     = ({1'b0, rd_ptr} == (len_q - (ADDR_W+1)'(1)));

  assign Busy      = (state == S_RUN) || (state == S_FLUSH);
  assign Done      = (state == S_DONE);
  assign Xout      = xout_q;
  assign Xvalid    = xvalid_q;
  assign State_dbg = state;

  // Writes are locked out during playback so a running record is never torn.
  ecg_sample_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .Clk   (Clk),
    .We    (Wr_en && !Busy),
    .Waddr (Wr_addr),
    .Wdata (Wr_data),
    .Re    (rd_fire),
    .Raddr (rd_ptr),
    .Rdata (ram_q)
  );

`ifdef STREAMER_ZERO_FLUSH_EN
  localparam int            FW     = $clog2(NTAPS);
  localparam logic [FW-1:0] F_LAST = FW'(NTAPS - 2);
  logic [FW-1:0] fcnt;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= S_IDLE;
      tick      <= '0;
      rd_ptr    <= '0;
      len_q     <= '0;
      loop_q    <= 1'b0;
      rd_stop   <= 1'b0;
      rd_valid  <= 1'b0;
      done_pend <= 1'b0;
      xout_q    <= '0;
      xvalid_q  <= 1'b0;
`ifdef STREAMER_ZERO_FLUSH_EN
      fcnt      <= '0;
`endif
    end else begin
      xvalid_q <= 1'b0;
      if (Stop) begin
        state     <= S_IDLE;
        tick      <= '0;
        rd_ptr    <= '0;
        rd_stop   <= 1'b0;
        rd_valid  <= 1'b0;
        done_pend <= 1'b0;
      end else if (start_ok) begin
        len_q     <= len_clamped;
        loop_q    <= Loop;
        tick      <= '0;
        rd_ptr    <= '0;
        rd_stop   <= 1'b0;
        rd_valid  <= 1'b0;
        done_pend <= 1'b0;
`ifdef STREAMER_ZERO_FLUSH_EN
        fcnt      <= '0;
`endif
        state     <= (len_clamped == '0) ? S_DONE : S_RUN;
      end else begin
        case (state)
          S_RUN: begin
            tick     <= (tick == T_MAX) ? '0 : tick + TW'(1);
            rd_valid <= rd_fire;
            if (rd_fire) begin
              if (is_last) begin
                rd_ptr <= '0;
                if (!loop_q) begin
                  rd_stop <= 1'b1;
                end
              end else begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
              end
            end
            // rd_stop together with rd_valid marks the final record sample.
            if (rd_valid) begin
              xout_q   <= ram_q;
              xvalid_q <= 1'b1;
              if (rd_stop) begin
`ifdef STREAMER_ZERO_FLUSH_EN
                state <= S_FLUSH;
`else
                done_pend <= 1'b1;
`endif
              end
            end
            if (done_pend) begin
              state <= S_DONE;
            end
          end
`ifdef STREAMER_ZERO_FLUSH_EN
          S_FLUSH: begin
            // Zeros land on tick==1, the same phase as record samples.
            tick <= (tick == T_MAX) ? '0 : tick + TW'(1);
            if (done_pend) begin
              state <= S_DONE;
            end else if (tick == TW'(1)) begin
              xout_q   <= '0;
              xvalid_q <= 1'b1;
              fcnt     <= fcnt + FW'(1);
              if (fcnt == F_LAST) begin
                done_pend <= 1'b1;
              end
            end
          end
`endif
          default: begin
          end
        endcase
      end
    end
  end

endmodule
